pulse_gen: RTL and testbench

//   Converts single-cycle trigger pulses on x into a clean output pulse train on a,

---
 rtl/pulse_pkg.sv | 19 +
 rtl/sat_updown_cnt.sv | 39 +++
 rtl/pulse_gen.sv | 114 +++++++++++
 tb/tb_pulse_gen.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared types and sizing helpers for the pulse generator.
// The timer is sized to hold the larger of the two phase lengths.
package pulse_pkg;

  typedef enum logic [1:0] {
    PG_IDLE = 2'd0,
    PG_HIGH = 2'd1,
    PG_LOW  = 2'd2
  } pulse_gen_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int timer_w(input int high_cyc, input int low_cyc);
    return $clog2(max_int(high_cyc, low_cyc) + 1);
  endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// Up/down counter that sticks at all-ones and at zero.
// Simultaneous inc and dec cancel, so the count holds.
module sat_updown_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         sat_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign sat_o = &cnt_q;
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && !sat_o) begin
      cnt_d = cnt_q + ONE;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pulse_gen.sv
// Turns single-cycle triggers into HIGH_CYC-wide pulses separated by at least
// LOW_CYC low cycles; triggers arriving mid-pulse wait in a saturating counter.
module pulse_gen
  import pulse_pkg::*;
#(
  parameter int HIGH_CYC = 3,
  parameter int LOW_CYC  = 3,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  output logic             a,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  localparam int TW = timer_w(HIGH_CYC, LOW_CYC);
  localparam logic [TW-1:0] HIGH_LOAD = TW'(HIGH_CYC - 1);
  localparam logic [TW-1:0] LOW_LOAD  = TW'(LOW_CYC - 1);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);

  pulse_gen_state_t state_q;
  logic [TW-1:0]    timer_q;
  logic             a_q;
  logic             busy_q;
  logic             ovf_q;

  logic timer_zero;
  logic pend_zero;
  logic start;
  logic cnt_inc;
  logic cnt_dec;
  logic cnt_sat;

  assign timer_zero = (timer_q == '0);
  assign pend_zero  = (pending == '0);
  assign start      = ((state_q == PG_IDLE) || ((state_q == PG_LOW) && timer_zero))
                      && (x || !pend_zero);

  // A queued trigger is served before a new one; a new trigger only bypasses
  // the queue when the queue is empty.
  assign cnt_inc = x && !(start && pend_zero);
  assign cnt_dec = start && !pend_zero;

  sat_updown_cnt #(
    .W(CNT_W)
  ) u_pend (
    .clk   (clk),
    .rst_n (rst),
    .inc_i (cnt_inc),
    .dec_i (cnt_dec),
    .cnt_o (pending),
    .sat_o (cnt_sat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PG_IDLE;
      timer_q <= '0;
      a_q     <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= cnt_inc && !cnt_dec && cnt_sat;
      case (state_q)
        PG_IDLE: begin
          if (start) begin
            state_q <= PG_HIGH;
            timer_q <= HIGH_LOAD;
            a_q     <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        PG_HIGH: begin
          if (timer_zero) begin
            state_q <= PG_LOW;
            timer_q <= LOW_LOAD;
            a_q     <= 1'b0;
          end else begin
            timer_q <= timer_q - TMR_ONE;
          end
        end
        PG_LOW: begin
          if (timer_zero) begin
            if (start) begin
              // back-to-back pulse, no idle gap
              state_q <= PG_HIGH;
              timer_q <= HIGH_LOAD;
              a_q     <= 1'b1;
            end else begin
              state_q <= PG_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            timer_q <= timer_q - TMR_ONE;
          end
        end
        default: begin
          state_q <= PG_IDLE;
          timer_q <= '0;
          a_q     <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a        = a_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Directed and random checks of pulse_gen against a timestamp-based model:
// each pulse is a start cycle, and the next pulse may begin HIGH+LOW cycles later.
module tb_pulse_gen;

  localparam int H    = 3;
  localparam int L    = 3;
  localparam int CW   = 2;
  localparam int PMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          x;
  logic          a;
  logic          busy;
  logic [CW-1:0] pending;
  logic          overflow;

  int checks = 0;
  int fails  = 0;

  int cyc;
  int pend;
  int next_free;
  int last_start;
  int xcount;
  int ovfcount;
  int rises;
  bit a_prev;

  pulse_gen #(
    .HIGH_CYC(H),
    .LOW_CYC (L),
    .CNT_W   (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .x       (x),
    .a       (a),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    pend       = 0;
    next_free  = 0;
    last_start = -1000;
    xcount     = 0;
    ovfcount   = 0;
    rises      = 0;
    a_prev     = 1'b0;
  endtask

  // Drive x for one cycle, advance the model across the edge, then compare.
  task automatic step(input bit xv);
    bit exp_ovf;
    x = xv;
    exp_ovf = 1'b0;
    if ((cyc + 1 >= next_free) && (pend != 0 || xv)) begin
      last_start = cyc + 1;
      next_free  = cyc + 1 + H + L;
      if (pend != 0) pend = pend - 1 + int'(xv);
    end else if (xv) begin
      if (pend == PMAX) exp_ovf = 1'b1;
      else pend++;
    end
    if (xv) xcount++;
    if (exp_ovf) ovfcount++;
    @(posedge clk);
    #1;
    cyc++;
    chk("a", 32'(a), 32'((cyc >= last_start) && (cyc < last_start + H)));
    chk("busy", 32'(busy), 32'(cyc < next_free));
    chk("pending", 32'(pending), 32'(pend));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    if (a && !a_prev) rises++;
    a_prev = a;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  initial begin
    rst = 1'b0;
    x   = 1'b1;
    cyc = 0;
    model_clear();

    // reset held with x asserted: everything stays quiet
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("rst_a", 32'(a), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
    end
    x   = 1'b0;
    rst = 1'b1;

    // single trigger
    step(1'b1);
    idle(8);
    // three back-to-back triggers
    step(1'b1); step(1'b1); step(1'b1);
    idle(20);
    // re-trigger on the last low cycle of a pulse
    step(1'b1);
    idle(5);
    step(1'b1);
    idle(12);
    // five triggers saturate the queue, one is dropped
    for (int i = 0; i < 5; i++) step(1'b1);
    idle(30);
    chk("ovf_count", 32'(ovfcount), 32'd1);
    chk("edges_vs_x", 32'(rises), 32'(xcount - ovfcount));

    // async reset in the middle of a high phase with a queue pending
    step(1'b1); step(1'b1); step(1'b1);
    chk("pre_rst_a", 32'(a), 32'd1);
    chk("pre_rst_pending", 32'(pending), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("async_a", 32'(a), 32'd0);
    chk("async_pending", 32'(pending), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    x = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b1;
    model_clear();
    idle(12);
    chk("post_rst_edges", 32'(rises), 32'd0);

    // random triggers, then drain and reconcile edge count
    model_clear();
    for (int i = 0; i < 400; i++) step(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
    idle(40);
    chk("rand_edges_vs_x", 32'(rises), 32'(xcount - ovfcount));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
